seq_alu_flags: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit ALU and its flag register, combined in one block. It adds carry-in arithmetic (ADC/SBC), a flags-only compare, arithmetic shift right, and multi-bit shifts executed one bit per cycle. It uses a start/busy/done handshake, holds a registered result, and writes the internal C/V/Z/N flag register when the operation completes. It sits between the register-file read ports and the datapath writeback in the next CPU generation.

---
 rtl/seq_alu_flags_pkg.sv | 37 +++
 rtl/seq_alu_addsub.sv | 38 +++
 rtl/seq_alu_flags.sv | 187 ++++++++++++++++++
 tb/tb_seq_alu_flags.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_flags_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_flags_pkg
//   Shared types for the sequential ALU: operation codes, FSM states, the
//   C/V/Z/N flag bundle and the default shift-amount width derivation.
// -----------------------------------------------------------------------------
package seq_alu_flags_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_ADC = 3'b010,
        OP_SBC = 3'b011,
        OP_SHR = 3'b100,
        OP_SHL = 3'b101,
        OP_CMP = 3'b110,
        OP_ASR = 3'b111
    } alu_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    // Narrowest shift-amount field that can still express a full-width shift
    // (and therefore also any larger request that must saturate to WIDTH).
    function automatic int shamt_w_default(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_alu_addsub.sv
// -----------------------------------------------------------------------------
// seq_alu_addsub
//   Combinational adder computing x + (y ^ {WIDTH{sub}}) + cin.
//   Ports:
//     x, y      operands
//     sub       invert y (two's-complement subtract together with cin=1)
//     cin       carry into the LSB
//     sum       WIDTH-bit result
//     carry     carry out of the MSB (for subtraction, 1 = no borrow)
//     overflow  carry into MSB XOR carry out of MSB
// -----------------------------------------------------------------------------
module seq_alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   full;
    // Sum of everything below the MSB; its top bit is the carry into the MSB.
    logic [WIDTH-1:0] low;

    assign y_eff = y ^ {WIDTH{sub}};
    assign full  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin};
    assign low   = {1'b0, x[WIDTH-2:0]} + {1'b0, y_eff[WIDTH-2:0]}
                 + {{(WIDTH-1){1'b0}}, cin};

    assign sum      = full[WIDTH-1:0];
    assign carry    = full[WIDTH];
    assign overflow = low[WIDTH-1] ^ full[WIDTH];

endmodule

// File: rtl/seq_alu_flags.sv
// -----------------------------------------------------------------------------
// seq_alu_flags
//   Multi-cycle ALU with an integrated C/V/Z/N flag register. Add/sub family
//   ops (ADD, SUB, ADC, SBC, CMP) complete in one cycle; shifts (SHR, SHL,
//   ASR) run one bit per cycle under a start/busy/done handshake.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start, op       request and operation code (accepted when busy=0)
//     a, b            operands; b[SHAMT_W-1:0] is the shift amount
//     flag_we         latch flags at completion when set
//     busy            multi-bit shift in progress
//     done            one-cycle completion pulse
//     result          registered result (CMP leaves it untouched)
//     carry_flag, overflow_flag, zero_flag, negative_flag   stored flags
// -----------------------------------------------------------------------------
module seq_alu_flags
    import seq_alu_flags_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = shamt_w_default(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flag_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             zero_flag,
    output logic             negative_flag
);

    // Requests longer than the datapath shift everything out; clamp so the
    // counter never runs past WIDTH cycles.
    function automatic logic [SHAMT_W-1:0] sat_shamt(input logic [SHAMT_W-1:0] raw);
        logic [SHAMT_W-1:0] k;
        if (raw > SHAMT_W'(WIDTH)) k = SHAMT_W'(WIDTH);
        else                       k = raw;
        return k;
    endfunction

    // One-bit shift step. Returns {bit shifted out, shifted value}.
    function automatic logic [WIDTH:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input alu_op_t          o);
        logic [WIDTH:0] r;
        case (o)
            OP_SHL:  r = {v, 1'b0};
            OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {v[0], 1'b0, v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    function automatic flags_t make_flags(input logic [WIDTH-1:0] val,
                                          input logic             c,
                                          input logic             v);
        flags_t f;
        f.c = c;
        f.v = v;
        f.z = (val == '0);
        f.n = val[WIDTH-1];
        return f;
    endfunction

    alu_op_t          op_in;
    logic             is_sub;
    logic             is_shift;
    logic             cin_in;
    logic [SHAMT_W-1:0] shamt;

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;

    logic [WIDTH-1:0] single_val;
    flags_t           single_flags;

    state_t             state;
    logic [SHAMT_W-1:0] count;
    logic               flag_we_q;
    flags_t             flags_q;
    logic [WIDTH-1:0]   work;
    alu_op_t            op_q;
    logic [WIDTH-1:0]   shift_next;
    logic               shift_cout;

    assign op_in = alu_op_t'(op);
    assign shamt = sat_shamt(b[SHAMT_W-1:0]);

    always_comb begin
        is_sub   = (op_in == OP_SUB) || (op_in == OP_SBC) || (op_in == OP_CMP);
        is_shift = (op_in == OP_SHR) || (op_in == OP_SHL) || (op_in == OP_ASR);
        // ADC/SBC chain the stored carry; the others use the plain +0 / +1.
        cin_in   = ((op_in == OP_ADC) || (op_in == OP_SBC)) ? flags_q.c : is_sub;
    end

    seq_alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .x        (a),
        .y        (b),
        .sub      (is_sub),
        .cin      (cin_in),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // Value and flags for anything finishing in the accept cycle. A zero
    // shift passes a through with C=V=0.
    always_comb begin
        if (is_shift) begin
            single_val   = a;
            single_flags = make_flags(a, 1'b0, 1'b0);
        end else begin
            single_val   = as_sum;
            single_flags = make_flags(as_sum, as_carry, as_ovf);
        end
    end

    assign {shift_cout, shift_next} = shift_one(work, op_q);

    // Control, result and flag state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
            count     <= '0;
            flag_we_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_shift && (shamt != '0)) begin
                            count     <= shamt;
                            flag_we_q <= flag_we;
                            busy      <= 1'b1;
                            state     <= ST_SHIFT;
                        end else begin
                            done <= 1'b1;
                            if (op_in != OP_CMP) result  <= single_val;
                            if (flag_we)         flags_q <= single_flags;
                        end
                    end
                end
                ST_SHIFT: begin
                    count <= count - 1'b1;
                    if (count == SHAMT_W'(1)) begin
                        result <= shift_next;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                        if (flag_we_q) flags_q <= make_flags(shift_next, shift_cout, 1'b0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift working register; pure data, loaded on acceptance
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            if (start && is_shift) begin
                work <= a;
                op_q <= op_in;
            end
        end else begin
            work <= shift_next;
        end
    end

    assign carry_flag    = flags_q.c;
    assign overflow_flag = flags_q.v;
    assign zero_flag     = flags_q.z;
    assign negative_flag = flags_q.n;

endmodule

// File: tb/tb_seq_alu_flags.sv
// -----------------------------------------------------------------------------
// tb_seq_alu_flags
//   Self-checking bench for seq_alu_flags (WIDTH=8, SHAMT_W=4). A behavioural
//   model computes results, flags and latency with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_seq_alu_flags;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 4;
    localparam int FULL    = 256;
    localparam int HALF    = 128;
    localparam int MASK    = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flag_we;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_flag;
    logic             overflow_flag;
    logic             zero_flag;
    logic             negative_flag;

    seq_alu_flags #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op            (op),
        .a             (a),
        .b             (b),
        .flag_we       (flag_we),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural state of the reference model
    int m_res = 0;
    int m_c = 0, m_v = 0, m_z = 0, m_n = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int dut_flags();
        return int'({carry_flag, overflow_flag, zero_flag, negative_flag});
    endfunction

    function automatic int model_flags();
        return m_c * 8 + m_v * 4 + m_z * 2 + m_n;
    endfunction

    function automatic int to_signed8(input int v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    // Computes the outcome of one operation from the arithmetic definition.
    task automatic model_op(input int opv, input int av, input int bv,
                            output int res, output int fc, output int fv,
                            output int fz, output int fn, output int k);
        int s, cin, yv, sum, ss, sa;
        k  = 0;
        fv = 0;
        fc = 0;
        res = 0;
        if (opv == 4 || opv == 5 || opv == 7) begin
            k = bv & 15;
            if (k > WIDTH) k = WIDTH;
            if (k == 0) begin
                res = av;
            end else if (opv == 5) begin
                res = (av << k) & MASK;
                fc  = (av >> (WIDTH - k)) & 1;
            end else if (opv == 4) begin
                res = av >> k;
                fc  = (av >> (k - 1)) & 1;
            end else begin
                sa  = to_signed8(av);
                res = (sa >>> k) & MASK;
                fc  = (sa >>> (k - 1)) & 1;
            end
        end else begin
            s   = (opv == 1 || opv == 3 || opv == 6) ? 1 : 0;
            cin = (opv == 2 || opv == 3) ? m_c : s;
            yv  = s ? (~bv & MASK) : bv;
            sum = av + yv + cin;
            res = sum & MASK;
            fc  = (sum >> WIDTH) & 1;
            ss  = to_signed8(av) + to_signed8(yv) + cin;
            fv  = (ss > HALF - 1 || ss < -HALF) ? 1 : 0;
        end
        fz = (res == 0) ? 1 : 0;
        fn = (res >= HALF) ? 1 : 0;
    endtask

    // Issue one op (assumed called just after a rising edge), wait for done,
    // check latency, busy duration, result and flags. With poke, a stray
    // start is raised while the shifter is busy and must be ignored.
    task automatic do_op(input int opv, input int av, input int bv,
                         input bit fwe, input bit poke, input string tag);
        int e_res, e_c, e_v, e_z, e_n, k, cyc, busy_cnt;
        model_op(opv, av, bv, e_res, e_c, e_v, e_z, e_n, k);
        op      = opv[2:0];
        a       = av[7:0];
        b       = bv[7:0];
        flag_we = fwe;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        op      = 3'($urandom_range(0, 7));
        a       = 8'($urandom_range(0, 255));
        b       = 8'($urandom_range(0, 255));
        flag_we = 1'($urandom_range(0, 1));
        if (poke && k > 0) start = 1'b1;
        cyc = 1;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, cyc, (k == 0) ? 1 : k + 1);
        check_eq({tag, "_busy_cycles"}, busy_cnt, k);
        check_eq({tag, "_busy_at_done"}, int'(busy), 0);
        if (opv != 6) m_res = e_res;
        if (fwe) begin
            m_c = e_c; m_v = e_v; m_z = e_z; m_n = e_n;
        end
        check_eq({tag, "_result"}, int'(result), m_res);
        check_eq({tag, "_flags"}, dut_flags(), model_flags());
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, int'(done), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_hold_result"}, int'(result), m_res);
        check_eq({tag, "_hold_flags"}, dut_flags(), model_flags());
    endtask

    initial begin
        int seen_done;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        a       = 8'd0;
        b       = 8'd0;
        flag_we = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_result", int'(result), 0);
        check_eq("reset_flags", dut_flags(), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases, issued back-to-back
        do_op(0, 'h7F, 'h01, 1'b1, 1'b0, "add");
        check_eq("plan_add_result", int'(result), 'h80);
        check_eq("plan_add_flags", dut_flags(), 4'b0101);
        do_op(1, 'h00, 'h01, 1'b1, 1'b0, "sub");
        check_eq("plan_sub_result", int'(result), 'hFF);
        check_eq("plan_sub_flags", dut_flags(), 4'b0001);
        do_op(3, 'h05, 'h02, 1'b1, 1'b0, "sbc");
        check_eq("plan_sbc_result", int'(result), 'h02);
        check_eq("plan_sbc_flags", dut_flags(), 4'b1000);
        do_op(5, 'hB5, 3, 1'b1, 1'b1, "shl");
        check_eq("plan_shl_result", int'(result), 'hA8);
        check_eq("plan_shl_flags", dut_flags(), 4'b1001);

        // Reset on the second SHIFT cycle aborts the shift
        op = 3'd5; a = 8'hFF; b = 8'd5; flag_we = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("rst_busy_before", int'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_result", int'(result), 0);
        check_eq("rst_flags", dut_flags(), 0);
        m_res = 0; m_c = 0; m_v = 0; m_z = 0; m_n = 0;
        seen_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check_eq("rst_no_late_done", seen_done, 0);

        do_op(7, 'h80, 9, 1'b1, 1'b0, "asr");
        check_eq("plan_asr_result", int'(result), 'hFF);
        check_eq("plan_asr_flags", dut_flags(), 4'b1001);
        do_op(4, 'h01, 0, 1'b1, 1'b0, "shr0");
        check_eq("plan_shr0_result", int'(result), 'h01);
        check_eq("plan_shr0_flags", dut_flags(), 4'b0000);
        idle_check("shr0_idle");
        do_op(6, 'h05, 'h05, 1'b1, 1'b0, "cmp");
        check_eq("plan_cmp_result", int'(result), 'h01);
        check_eq("plan_cmp_flags", dut_flags(), 4'b1010);
        do_op(0, 'hFF, 'h01, 1'b0, 1'b0, "add_nowe");
        check_eq("plan_add_nowe_result", int'(result), 'h00);
        check_eq("plan_add_nowe_flags", dut_flags(), 4'b1010);
        idle_check("directed_idle");

        // Randomised traffic, mixing back-to-back and idle gaps
        for (int i = 0; i < 150; i++) begin
            int rop, ra, rb, pick;
            rop  = $urandom_range(0, 7);
            pick = $urandom_range(0, 7);
            case (pick)
                0:       ra = 'h00;
                1:       ra = 'h7F;
                2:       ra = 'h80;
                3:       ra = 'hFF;
                default: ra = $urandom_range(0, 255);
            endcase
            rb = $urandom_range(0, 255);
            do_op(rop, ra, rb, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), "rnd");
            if ($urandom_range(0, 1) == 1) idle_check("rnd_idle");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
